// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: decouples instruction memory from the fetch/decode front end.
// Issues sequential word fetches, queues returned instructions with their PC, and
// presents one instruction per cycle through the IF_* output register.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-redirect flag).
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_vld,
    input  logic [31:0] jmp_addr,
    input  logic        hold,
    output logic        imem_req_vld,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    output logic        IF_vld,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [31:0]   rspPc_q, rspPc_d;
    logic [31:0]   qPc_q [DEPTH];
    logic [31:0]   qInst_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          ifVld_q, ifVld_d;
    logic [31:0]   ifPc_q, ifPc_d;
    logic [31:0]   ifInst_q, ifInst_d;

    logic [31:0]   jmpTarget;
    logic          misalignFlag;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          rspLive;
    logic          push;
    logic          pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    assign jmpTarget    = jmp_addr;
    assign misalignFlag = misalign_q;

    // Sticky flag: set by a misaligned redirect, cleared only by an aligned one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (jmp_vld) begin
            misalign_q <= (jmp_addr[1:0] != 2'b00);
        end
    end
`else
    logic [1:0] unusedJmpLsbs;

    assign unusedJmpLsbs = jmp_addr[1:0];
    assign jmpTarget     = {jmp_addr[31:2], 2'b00};
    assign misalignFlag  = 1'b0;
`endif

    // Slots are reserved at accept time, so queued plus in-flight never exceeds DEPTH
    assign occupancy     = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_vld  = (occupancy < DEPTH_W) && (outstanding_q < MAX_W) && !jmp_vld && !misalignFlag;
    assign imem_req_addr = fetchPc_q;
    assign accept        = imem_req_vld && imem_req_rdy;
    assign rspLive       = imem_rsp_vld && (outstanding_q != '0);
    assign push          = rspLive && (discard_q == '0) && !jmp_vld;
    assign pop           = !jmp_vld && !hold && (count_q != '0);

    assign IF_vld      = ifVld_q;
    assign IF_pc       = ifPc_q;
    assign IF_inst     = ifInst_q;
    assign IF_misalign = misalignFlag;

    // Next-state: a redirect overrides everything; otherwise pop-before-push so no bypass
    always_comb begin
        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        ifVld_d       = ifVld_q;
        ifPc_d        = ifPc_q;
        ifInst_d      = ifInst_q;
        if (jmp_vld) begin
            fetchPc_d     = jmpTarget;
            rspPc_d       = jmpTarget;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            outstanding_d = outstanding_q - CW'(rspLive);
            // outstanding already counts earlier stale requests, so every request
            // still in flight after this edge is stale: that is the new discard count
            discard_d     = outstanding_q - CW'(rspLive);
            ifVld_d       = 1'b0;
        end else begin
            if (accept) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(rspLive);
            if (rspLive && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                tail_d  = tail_q + PW'(1);
                rspPc_d = rspPc_q + 32'd4;
            end
            if (pop) begin
                head_d   = head_q + PW'(1);
                ifVld_d  = 1'b1;
                ifPc_d   = qPc_q[head_q];
                ifInst_d = qInst_q[head_q];
            end else if (!hold) begin
                ifVld_d = 1'b0;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            ifVld_q       <= 1'b0;
            ifPc_q        <= 32'h0;
            ifInst_q      <= 32'h0000_0013;
        end else begin
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            ifVld_q       <= ifVld_d;
            ifPc_q        <= ifPc_d;
            ifInst_q      <= ifInst_d;
        end
    end

    // Queue storage; validity is tracked by head/tail/count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            qPc_q[tail_q]   <= rspPc_q;
            qInst_q[tail_q] <= imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    rspWithoutRequest: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_vld && (outstanding_q == '0)));
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Testbench for inst_prefetch_buffer: randomized imem model plus a queue-based
// reference model of the fetch buffer (in-flight list with stale marks).
module tb_inst_prefetch_buffer;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp_vld;
    logic [31:0] jmp_addr;
    logic        hold;
    logic        imem_req_vld;
    logic        imem_req_rdy;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_data;
    logic        IF_vld;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic        IF_misalign;

    int vectors    = 0;
    int miscompares = 0;
    int cycleNo    = 0;

    typedef struct {logic [31:0] addr; int due;} pend_t;
    typedef struct {logic [31:0] pc; logic stale;} flight_t;
    typedef struct {logic [31:0] pc; logic [31:0] inst;} entry_t;

    pend_t   pendQ[$];
    int      lastDue;
    int      rdyPct;
    int      latMin;
    int      latMax;
    logic [31:0] salt;

    flight_t inflight[$];
    entry_t  bufQ[$];
    logic [31:0] mFetchPc;
    logic        mIfVld;
    logic [31:0] mIfPc;
    logic [31:0] mIfInst;
    logic        mMisalign;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .jmp_vld(jmp_vld), .jmp_addr(jmp_addr), .hold(hold),
        .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req_addr(imem_req_addr),
        .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
        .IF_vld(IF_vld), .IF_pc(IF_pc), .IF_inst(IF_inst), .IF_misalign(IF_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    // Hold reset for two cycles and return the imem and reference model to their reset state
    task automatic doReset();
        rst = 1'b1; jmp_vld = 1'b0; jmp_addr = 32'h0; hold = 1'b0;
        imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rsp_data = 32'h0;
        repeat (2) @(negedge clk);
        pendQ.delete(); inflight.delete(); bufQ.delete();
        lastDue = cycleNo;
        mFetchPc = 32'h0; mIfVld = 1'b0; mIfPc = 32'h0; mIfInst = 32'h13; mMisalign = 1'b0;
        rst = 1'b0;
    endtask

    // One clock cycle: entered and left at a negedge
    task automatic step(input logic h, input int jmpMode, input logic [31:0] target, output logic jumped);
        logic        rsp;
        logic [31:0] rspAddr;
        logic        expReq;
        logic        accept;
        logic [31:0] acceptAddr;
        int          lat;
        pend_t       p;
        flight_t     f;
        entry_t      e;
        cycleNo++;
        rsp = 1'b0;
        rspAddr = 32'h0;
        if (pendQ.size() > 0 && pendQ[0].due <= cycleNo) begin
            rsp = 1'b1;
            rspAddr = pendQ[0].addr;
            void'(pendQ.pop_front());
        end
        imem_rsp_vld  = rsp;
        imem_rsp_data = rsp ? memWord(rspAddr) : $urandom;
        imem_req_rdy  = ($urandom_range(99) < rdyPct);
        jumped   = (jmpMode == 1) || (jmpMode == 2 && rsp);
        jmp_vld  = jumped;
        jmp_addr = target;
        hold     = h;
        #1;
        expReq = ((bufQ.size() + inflight.size()) < DEPTH) && (inflight.size() < MAX_OUT) && !jumped && !mMisalign;
        vectors++;
        if (imem_req_vld !== expReq) begin
            miscompares++;
            $display("[TB] FAIL req_vld cycle %0d: got %b expected %b", cycleNo, imem_req_vld, expReq);
        end
        if (expReq) begin
            vectors++;
            if (imem_req_addr !== mFetchPc) begin
                miscompares++;
                $display("[TB] FAIL req_addr cycle %0d: got %h expected %h", cycleNo, imem_req_addr, mFetchPc);
            end
        end
        accept = (imem_req_vld === 1'b1) && imem_req_rdy;
        acceptAddr = imem_req_addr;
        if (accept) begin
            lat = $urandom_range(latMax, latMin);
            p.addr = acceptAddr;
            p.due = cycleNo + lat;
            if (p.due <= lastDue) p.due = lastDue + 1;
            lastDue = p.due;
            pendQ.push_back(p);
        end
        @(posedge clk);
        if (jumped) begin
            if (rsp && inflight.size() > 0) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            bufQ.delete();
            mIfVld = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mMisalign = (target[1:0] != 2'b00);
            mFetchPc = target;
`else
            mFetchPc = {target[31:2], 2'b00};
`endif
        end else begin
            if (!h) begin
                if (bufQ.size() > 0) begin
                    e = bufQ.pop_front();
                    mIfVld = 1'b1; mIfPc = e.pc; mIfInst = e.inst;
                end else begin
                    mIfVld = 1'b0;
                end
            end
            if (rsp && inflight.size() > 0) begin
                f = inflight.pop_front();
                if (!f.stale) begin
                    e.pc = f.pc; e.inst = memWord(f.pc);
                    bufQ.push_back(e);
                end
            end
            if (accept) begin
                f.pc = mFetchPc; f.stale = 1'b0;
                inflight.push_back(f);
                mFetchPc = mFetchPc + 32'd4;
            end
        end
        #1;
        vectors++;
        if (IF_vld !== mIfVld || IF_pc !== mIfPc || IF_inst !== mIfInst || IF_misalign !== mMisalign) begin
            miscompares++;
            $display("[TB] FAIL if_out cycle %0d: got vld=%b pc=%h inst=%h mis=%b expected vld=%b pc=%h inst=%h mis=%b",
                     cycleNo, IF_vld, IF_pc, IF_inst, IF_misalign, mIfVld, mIfPc, mIfInst, mMisalign);
        end
        @(negedge clk);
    endtask

    // Run until the next valid instruction and check it is the expected redirect target
    task automatic expectFirstValid(input logic [31:0] expPc, input string name);
        logic j;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 0, 32'h0, j);
            if (IF_vld === 1'b1) begin
                found = 1'b1;
                vectors++;
                if (IF_pc !== expPc || IF_inst !== memWord(expPc)) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got pc=%h inst=%h expected pc=%h inst=%h", name, IF_pc, IF_inst, expPc, memWord(expPc));
                end
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: no valid output within 20 cycles, expected pc=%h", name, expPc);
        end
    endtask

    task automatic test_reset();
        logic j;
        salt = 32'h0; rdyPct = 100; latMin = 1; latMax = 1;
        doReset();
        #1;
        vectors++;
        if (IF_vld !== 1'b0 || IF_pc !== 32'h0 || IF_inst !== 32'h13 || IF_misalign !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got vld=%b pc=%h inst=%h mis=%b expected 0/00000000/00000013/0", IF_vld, IF_pc, IF_inst, IF_misalign);
        end
        vectors++;
        if (imem_req_vld !== 1'b1 || imem_req_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_req: got vld=%b addr=%h expected 1/00000000", imem_req_vld, imem_req_addr);
        end
        @(negedge clk);
        repeat (6) step(1'b0, 0, 32'h0, j);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (IF_vld !== 1'b0 || IF_inst !== 32'h13 || imem_req_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got vld=%b inst=%h addr=%h expected 0/00000013/00000000", IF_vld, IF_inst, imem_req_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic j;
        salt = 32'h0; rdyPct = 100; latMin = 1; latMax = 1;
        doReset();
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 0, 32'h0, j);
            if (k >= 3) begin
                vectors++;
                if (IF_vld !== 1'b1 || IF_pc !== 32'((k - 3) * 4) || IF_inst !== 32'(k - 3)) begin
                    miscompares++;
                    $display("[TB] FAIL stream_k%0d: got vld=%b pc=%h inst=%h expected 1/%h/%h", k, IF_vld, IF_pc, IF_inst, 32'((k - 3) * 4), 32'(k - 3));
                end
            end
        end
    endtask

    task automatic test_hold();
        logic j;
        salt = 32'h0; rdyPct = 100; latMin = 1; latMax = 1;
        doReset();
        repeat (7) step(1'b0, 0, 32'h0, j);
        repeat (5) step(1'b1, 0, 32'h0, j);
        repeat (6) step(1'b0, 0, 32'h0, j);
    endtask

    task automatic test_jump_stale();
        logic j;
        salt = 32'h1234_0000; rdyPct = 100; latMin = 3; latMax = 3;
        doReset();
        repeat (6) step(1'b0, 0, 32'h0, j);
        step(1'b0, 1, 32'h200, j);
        expectFirstValid(32'h200, "jump_target");
        repeat (6) step(1'b0, 0, 32'h0, j);
        step(1'b0, 1, 32'hFFFF_FFF8, j);
        repeat (10) step(1'b0, 0, 32'h0, j);
    endtask

    task automatic test_jump_with_rsp_hold();
        logic j;
        logic taken;
        salt = 32'h00AB_0000; rdyPct = 100; latMin = 1; latMax = 2;
        doReset();
        repeat (5) step(1'b0, 0, 32'h0, j);
        taken = 1'b0;
        for (int i = 0; i < 20 && !taken; i++) begin
            step(1'b1, 2, 32'h340, j);
            taken = j;
        end
        vectors++;
        if (!taken) begin
            miscompares++;
            $display("[TB] FAIL jump_rsp_hold: no response cycle within 20 cycles, expected one");
        end
        expectFirstValid(32'h340, "jump_rsp_target");
        repeat (8) step(1'b0, 0, 32'h0, j);
    endtask

    task automatic test_random();
        logic j;
        logic h;
        int   mode;
        logic [31:0] tgt;
        salt = 32'h5A5A_0000; rdyPct = 50; latMin = 1; latMax = 4;
        doReset();
        for (int i = 0; i < 2000; i++) begin
            h = ($urandom_range(99) < 25);
            mode = ($urandom_range(99) < 3) ? 1 : 0;
            tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step(h, mode, tgt, j);
        end
    endtask

    task automatic test_misalign();
        logic j;
        salt = 32'h0F0F_0000; rdyPct = 100; latMin = 1; latMax = 2;
        doReset();
        repeat (5) step(1'b0, 0, 32'h0, j);
        step(1'b0, 1, 32'h102, j);
        repeat (6) step(1'b0, 0, 32'h0, j);
        step(1'b1, 1, 32'h100, j);
        expectFirstValid(32'h100, "misalign_recover");
        repeat (4) step(1'b0, 0, 32'h0, j);
    endtask

    initial begin
        rst = 1'b1; jmp_vld = 1'b0; jmp_addr = 32'h0; hold = 1'b0;
        imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rsp_data = 32'h0;
        salt = 32'h0; rdyPct = 100; latMin = 1; latMax = 1; lastDue = 0;
        test_reset();
        test_stream();
        test_hold();
        test_jump_stale();
        test_jump_with_rsp_hold();
        test_random();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
